// File: rtl/controlador_display_if.sv
// controlador_display_if: sensor/state inputs and 7-segment pins of the display scan controller
interface controlador_display_if;
  logic       enable_i;
  logic [2:0] piso_gray_i;
  logic [1:0] dir_i;
  logic       puerta_i;
  logic       sobrepeso_i;
  logic [6:0] seg_o;
  logic [3:0] an_o;
  modport master (output enable_i, piso_gray_i, dir_i, puerta_i, sobrepeso_i, input seg_o, an_o);
  modport slave  (input enable_i, piso_gray_i, dir_i, puerta_i, sobrepeso_i, output seg_o, an_o);
endinterface

// File: rtl/controlador_display.sv
// controlador_display: 4-digit multiplexed 7-segment scan with anti-ghost blanking, frame snapshots and overweight blink
module controlador_display #(
  parameter int PRESCALE     = 100000,
  parameter int BLANK        = 1000,
  parameter int BLINK_FRAMES = 125
) (
  input logic                  _clk_,
  input logic                  _reset_i,
  controlador_display_if.slave bus
);
  localparam int CW = (PRESCALE > BLANK) ? $clog2(PRESCALE) : $clog2(BLANK);
  localparam int SW = (CW < 1) ? 1 : CW;
  localparam int FW = (BLINK_FRAMES < 2) ? 1 : $clog2(BLINK_FRAMES);
  localparam logic [0:0] S_BLANK = 1'b0;
  localparam logic [0:0] S_SCAN  = 1'b1;
  logic [0:0]    r_state;
  logic [1:0]    r_d;
  logic [SW-1:0] r_cnt;
  logic [2:0]    r_gray;
  logic [1:0]    r_dir;
  logic          r_puerta;
  logic          r_sob;
  logic          r_show;
  logic          r_flag;
  logic [FW-1:0] r_fc;
  logic [6:0]    r_seg;
  logic [3:0]    r_an;
  logic          w_end_blank;
  logic          w_end_scan;
  logic          w_take;
  logic [2:0]    w_gray;
  logic [6:0]    w_floor;
  logic [6:0]    w_dig1;
  logic [6:0]    w_dig2;
  logic [6:0]    w_dig3;
  logic [6:0]    w_pat;
  logic [3:0]    w_an;
  assign bus.seg_o = r_seg;
  assign bus.an_o  = r_an;
  always_comb begin
    w_end_blank = (r_state == S_BLANK) && (r_cnt == SW'(BLANK - 1));
    w_end_scan  = (r_state == S_SCAN) && (r_cnt == SW'(PRESCALE - 1));
    w_take      = w_end_blank && (r_d == 2'd0);
    // digit 0 is lit on the snapshot edge itself, so it decodes the value being sampled
    w_gray      = w_take ? bus.piso_gray_i : r_gray;
    w_floor     = (w_gray == 3'b000) ? 7'h40 :
                  (w_gray == 3'b001) ? 7'h79 :
                  (w_gray == 3'b011) ? 7'h24 :
                  (w_gray == 3'b010) ? 7'h30 :
                  (w_gray == 3'b110) ? 7'h19 : 7'h3F;
    w_dig1      = (r_dir == 2'b01) ? 7'h41 : (r_dir == 2'b10) ? 7'h21 : 7'h7F;
    w_dig2      = r_puerta ? 7'h0C : 7'h7F;
    w_dig3      = (r_sob && r_show) ? 7'h12 : 7'h7F;
    w_pat       = (r_d == 2'd0) ? w_floor : (r_d == 2'd1) ? w_dig1 : (r_d == 2'd2) ? w_dig2 : w_dig3;
    w_an        = ~(4'b0001 << r_d);
  end
  always_ff @(posedge _clk_ or negedge _reset_i) begin
    if (!_reset_i) begin
      r_state <= S_BLANK;
      r_d     <= 2'd0;
      r_cnt   <= '0;
      r_seg   <= 7'h7F;
      r_an    <= 4'b1111;
    end else if (!bus.enable_i) begin
      r_state <= S_BLANK;
      r_d     <= 2'd0;
      r_cnt   <= '0;
      r_seg   <= 7'h7F;
      r_an    <= 4'b1111;
    end else if (w_end_blank) begin
      r_state <= S_SCAN;
      r_cnt   <= '0;
      r_seg   <= w_pat;
      r_an    <= w_an;
    end else if (w_end_scan) begin
      r_state <= S_BLANK;
      r_d     <= r_d + 2'd1;
      r_cnt   <= '0;
      r_seg   <= 7'h7F;
      r_an    <= 4'b1111;
    end else begin
      r_cnt   <= r_cnt + SW'(1);
    end
  end
  // the frame displays the flag as it stood before this snapshot's blink update
  always_ff @(posedge _clk_ or negedge _reset_i) begin
    if (!_reset_i) begin
      r_gray   <= 3'b000;
      r_dir    <= 2'b00;
      r_puerta <= 1'b0;
      r_sob    <= 1'b0;
      r_show   <= 1'b1;
      r_flag   <= 1'b1;
      r_fc     <= '0;
    end else if (bus.enable_i && w_take) begin
      r_gray   <= bus.piso_gray_i;
      r_dir    <= bus.dir_i;
      r_puerta <= bus.puerta_i;
      r_sob    <= bus.sobrepeso_i;
      r_show   <= r_flag;
      r_fc     <= (!bus.sobrepeso_i || r_fc == FW'(BLINK_FRAMES - 1)) ? '0 : r_fc + FW'(1);
      r_flag   <= !bus.sobrepeso_i ? 1'b1 : (r_fc == FW'(BLINK_FRAMES - 1)) ? ~r_flag : r_flag;
    end
  end
endmodule

// File: tb/tb_controlador_display.sv
// tb_controlador_display: directed scan, snapshot, blink, enable and async reset checks at PRESCALE=4 BLANK=2 BLINK_FRAMES=2
module tb_controlador_display;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  controlador_display_if bus();
  controlador_display #(.PRESCALE(4), .BLANK(2), .BLINK_FRAMES(2)) dut (._clk_(clk), ._reset_i(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [3:0] an, input logic [6:0] seg);
    n_cmp++;
    assert ({bus.an_o, bus.seg_o} === {an, seg}) else begin
      n_bad++;
      $error("FAIL %s: an_o=%b seg_o=%h expected an_o=%b seg_o=%h", tag, bus.an_o, bus.seg_o, an, seg);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_n(input string tag, input int n, input logic [3:0] an, input logic [6:0] seg);
    repeat (n) begin
      tick();
      chk(tag, an, seg);
    end
  endtask
  task automatic frame(input string tag, input int nb, input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3);
    expect_n({tag, "_b0"}, nb, 4'b1111, 7'h7F);
    expect_n({tag, "_d0"}, 4, 4'b1110, s0);
    expect_n({tag, "_b1"}, 2, 4'b1111, 7'h7F);
    expect_n({tag, "_d1"}, 4, 4'b1101, s1);
    expect_n({tag, "_b2"}, 2, 4'b1111, 7'h7F);
    expect_n({tag, "_d2"}, 4, 4'b1011, s2);
    expect_n({tag, "_b3"}, 2, 4'b1111, 7'h7F);
    expect_n({tag, "_d3"}, 4, 4'b0111, s3);
  endtask
  logic [2:0] gray_v [6] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111};
  logic [6:0] seg_v  [6] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h3F};
  initial begin
    bus.enable_i    = 1'b1;
    bus.piso_gray_i = 3'b011;
    bus.dir_i       = 2'b00;
    bus.puerta_i    = 1'b0;
    bus.sobrepeso_i = 1'b0;
    tick();
    tick();
    chk("reset", 4'b1111, 7'h7F);
    rst_n = 1'b1;
    frame("rel_f1", 1, 7'h24, 7'h7F, 7'h7F, 7'h7F);
    frame("rel_f2", 2, 7'h24, 7'h7F, 7'h7F, 7'h7F);
    for (int i = 0; i < 6; i++) begin
      bus.piso_gray_i = gray_v[i];
      frame($sformatf("floor%0d", i), 2, seg_v[i], 7'h7F, 7'h7F, 7'h7F);
    end
    bus.piso_gray_i = 3'b001;
    bus.dir_i       = 2'b01;
    bus.puerta_i    = 1'b1;
    frame("dir_up", 2, 7'h79, 7'h41, 7'h0C, 7'h7F);
    expect_n("mid_b0", 2, 4'b1111, 7'h7F);
    expect_n("mid_d0a", 2, 4'b1110, 7'h79);
    bus.dir_i = 2'b10;
    expect_n("mid_d0b", 2, 4'b1110, 7'h79);
    expect_n("mid_b1", 2, 4'b1111, 7'h7F);
    expect_n("mid_d1_old", 4, 4'b1101, 7'h41);
    expect_n("mid_b2", 2, 4'b1111, 7'h7F);
    expect_n("mid_d2", 4, 4'b1011, 7'h0C);
    expect_n("mid_b3", 2, 4'b1111, 7'h7F);
    expect_n("mid_d3", 4, 4'b0111, 7'h7F);
    frame("dir_down", 2, 7'h79, 7'h21, 7'h0C, 7'h7F);
    bus.dir_i       = 2'b00;
    bus.puerta_i    = 1'b0;
    bus.sobrepeso_i = 1'b1;
    frame("ow_f1", 2, 7'h79, 7'h7F, 7'h7F, 7'h12);
    frame("ow_f2", 2, 7'h79, 7'h7F, 7'h7F, 7'h12);
    frame("ow_f3", 2, 7'h79, 7'h7F, 7'h7F, 7'h7F);
    frame("ow_f4", 2, 7'h79, 7'h7F, 7'h7F, 7'h7F);
    frame("ow_f5", 2, 7'h79, 7'h7F, 7'h7F, 7'h12);
    frame("ow_f6", 2, 7'h79, 7'h7F, 7'h7F, 7'h12);
    bus.sobrepeso_i = 1'b0;
    frame("ow_drop", 2, 7'h79, 7'h7F, 7'h7F, 7'h7F);
    bus.sobrepeso_i = 1'b1;
    frame("ow_reraise", 2, 7'h79, 7'h7F, 7'h7F, 7'h12);
    bus.sobrepeso_i = 1'b0;
    bus.dir_i       = 2'b01;
    bus.puerta_i    = 1'b1;
    expect_n("en_b0", 2, 4'b1111, 7'h7F);
    expect_n("en_d0", 4, 4'b1110, 7'h79);
    expect_n("en_b1", 2, 4'b1111, 7'h7F);
    expect_n("en_d1", 4, 4'b1101, 7'h41);
    expect_n("en_b2", 2, 4'b1111, 7'h7F);
    expect_n("en_d2", 2, 4'b1011, 7'h0C);
    bus.enable_i = 1'b0;
    expect_n("en_off", 3, 4'b1111, 7'h7F);
    bus.piso_gray_i = 3'b010;
    expect_n("en_off_hold", 2, 4'b1111, 7'h7F);
    bus.enable_i = 1'b1;
    frame("en_back", 1, 7'h30, 7'h41, 7'h0C, 7'h7F);
    expect_n("rst_b0", 2, 4'b1111, 7'h7F);
    expect_n("rst_d0", 4, 4'b1110, 7'h30);
    expect_n("rst_b1", 2, 4'b1111, 7'h7F);
    expect_n("rst_d1", 2, 4'b1101, 7'h41);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", 4'b1111, 7'h7F);
    bus.piso_gray_i = 3'b011;
    bus.dir_i       = 2'b00;
    bus.puerta_i    = 1'b0;
    tick();
    chk("rst_hold", 4'b1111, 7'h7F);
    rst_n = 1'b1;
    frame("rst_rec", 1, 7'h24, 7'h7F, 7'h7F, 7'h7F);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
